// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen
//
// Raster timing source for the renderer and the HDMI/TMDS output path.
// It runs free horizontal and vertical counters, 1280x720 visible out of
// 1650x750 total by default, and advances one pixel per clock enable.
// Every output is registered and decoded from the same next count, so the
// sync and draw flags always describe the pixel shown on hcount/vcount.
//
// Ports:
//   clk_in           system clock; all state changes on the rising edge
//   rst_in           asynchronous reset, active-low (0 = reset)
//   ce_in            pixel enable; counters advance only while it is high
//   hcount_out       current pixel column, 0..H_TOTAL-1
//   vcount_out       current line, 0..V_TOTAL-1
//   hsync_out        horizontal sync, active-high
//   vsync_out        vertical sync, active-high, held for whole lines
//   active_draw_out  high inside the visible area
//   frame_start_out  one-clock strobe at (ACTIVE_H, ACTIVE_V), which is
//                    the start of vertical blanking
//   frame_count_out  frame index, 0..FPS-1
// ---------------------------------------------------------------------------
module video_timing_gen #(
  parameter int ACTIVE_H = 1280,
  parameter int H_FRONT  = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BACK   = 220,
  parameter int ACTIVE_V = 720,
  parameter int V_FRONT  = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BACK   = 20,
  parameter int FPS      = 60
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        ce_in,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        active_draw_out,
  output logic        frame_start_out,
  output logic [5:0]  frame_count_out
);

  localparam int H_TOTAL  = ACTIVE_H + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = ACTIVE_V + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = ACTIVE_H + H_FRONT;
  localparam int VS_START = ACTIVE_V + V_FRONT;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(ACTIVE_H);
  localparam logic [10:0] HS_LO  = 11'(HS_START);
  localparam logic [10:0] HS_HI  = 11'(HS_START + H_SYNC);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT  = 10'(ACTIVE_V);
  localparam logic [9:0]  VS_LO  = 10'(VS_START);
  localparam logic [9:0]  VS_HI  = 10'(VS_START + V_SYNC);
  localparam logic [5:0]  FC_LAST = 6'(FPS - 1);

  // UNPRIMED: outputs read all-zero after reset; the first enabled edge
  // loads pixel (0,0) without advancing. RUN: one pixel per enabled edge.
  typedef enum logic {UNPRIMED, RUN} state_t;

  state_t      state_q, state_d;
  logic [10:0] hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        active_draw_q, active_draw_d;
  logic        frame_start_q, frame_start_d;
  logic [5:0]  frame_count_q, frame_count_d;

  // Next-pixel computation. The flags are decoded from the next count, not
  // the current one, so they land in the same register stage as the count.
  // The frame strobe defaults low so it drops even while ce_in is low.
  always_comb begin
    state_d       = state_q;
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    active_draw_d = active_draw_q;
    frame_start_d = 1'b0;
    frame_count_d = frame_count_q;

    if (ce_in) begin
      if (state_q == UNPRIMED) begin
        state_d  = RUN;
        hcount_d = '0;
        vcount_d = '0;
      end else if (hcount_q == H_LAST) begin
        hcount_d = '0;
        vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
      end else begin
        hcount_d = hcount_q + 11'd1;
      end

      hsync_d       = (hcount_d >= HS_LO) && (hcount_d < HS_HI);
      vsync_d       = (vcount_d >= VS_LO) && (vcount_d < VS_HI);
      active_draw_d = (hcount_d < H_ACT) && (vcount_d < V_ACT);

      // Only a real advance can reach the strobe point, never the priming load
      if ((state_q == RUN) && (hcount_d == H_ACT) && (vcount_d == V_ACT)) begin
        frame_start_d = 1'b1;
        frame_count_d = (frame_count_q == FC_LAST) ? '0 : frame_count_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q       <= UNPRIMED;
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      active_draw_q <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_draw_q <= active_draw_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign hcount_out      = hcount_q;
  assign vcount_out      = vcount_q;
  assign hsync_out       = hsync_q;
  assign vsync_out       = vsync_q;
  assign active_draw_out = active_draw_q;
  assign frame_start_out = frame_start_q;
  assign frame_count_out = frame_count_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_video_timing_gen
//
// Bench for video_timing_gen. It uses a shrunken raster so that whole
// frames fit in a short run:
//   horizontal 8 visible + 2 front + 3 sync + 3 back = 16 total,
//     so hsync is high for h in [10,13)
//   vertical   6 visible + 1 front + 2 sync + 1 back = 10 total,
//     so vsync is high for v in [7,9)
//   one frame is 160 enabled clocks, the strobe is at (8,6), and FPS = 4
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_video_timing_gen;

  logic        clk_in;
  logic        rst_in;
  logic        ce_in;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        active_draw_out;
  logic        frame_start_out;
  logic [5:0]  frame_count_out;

  int checks;
  int passed;

  // Reference model state, advanced once per sampled clock
  bit       m_primed;
  int       m_h;
  int       m_v;
  bit       m_fs;
  int       m_fc;

  video_timing_gen #(
    .ACTIVE_H(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .ACTIVE_V(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .FPS(4)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .ce_in           (ce_in),
    .hcount_out      (hcount_out),
    .vcount_out      (vcount_out),
    .hsync_out       (hsync_out),
    .vsync_out       (vsync_out),
    .active_draw_out (active_draw_out),
    .frame_start_out (frame_start_out),
    .frame_count_out (frame_count_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // All DUT outputs packed as {h, v, hsync, vsync, active, start, count}
  function automatic logic [30:0] dut_vec();
    return {hcount_out, vcount_out, hsync_out, vsync_out,
            active_draw_out, frame_start_out, frame_count_out};
  endfunction

  // Expected packed output vector derived from the model state
  function automatic logic [30:0] model_vec();
    logic hs, vs, ad;
    if (!m_primed) return '0;
    hs = (m_h >= 10) && (m_h < 13);
    vs = (m_v >= 7) && (m_v < 9);
    ad = (m_h < 8) && (m_v < 6);
    return {11'(m_h), 10'(m_v), hs, vs, ad, m_fs, 6'(m_fc)};
  endfunction

  task automatic model_reset();
    m_primed = 1'b0;
    m_h = 0;
    m_v = 0;
    m_fs = 1'b0;
    m_fc = 0;
  endtask

  // Advance the model by one clock edge with the given enable level
  task automatic model_step(input bit ce);
    m_fs = 1'b0;
    if (ce) begin
      if (!m_primed) begin
        m_primed = 1'b1;
        m_h = 0;
        m_v = 0;
      end else if (m_h == 15) begin
        m_h = 0;
        m_v = (m_v == 9) ? 0 : m_v + 1;
        m_fs = (m_h == 8) && (m_v == 6);
      end else begin
        m_h = m_h + 1;
        m_fs = (m_h == 8) && (m_v == 6);
      end
      if (m_fs) m_fc = (m_fc + 1) % 4;
    end
  endtask

  // Reset held with the enable high, then the priming edge and first advance
  task automatic test_reset();
    rst_in = 1'b0;
    ce_in  = 1'b1;
    repeat (3) @(negedge clk_in);
    checks++;
    if (dut_vec() !== 31'd0)
      $display("[TB] FAIL reset_outputs: got %h expected %h", dut_vec(), 31'd0);
    else passed++;

    rst_in = 1'b1;
    model_reset();
    @(negedge clk_in);
    model_step(1'b1);
    checks++;
    if (dut_vec() !== {11'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0})
      $display("[TB] FAIL prime_origin: got %h expected %h", dut_vec(),
               {11'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0});
    else passed++;

    @(negedge clk_in);
    model_step(1'b1);
    checks++;
    if (dut_vec() !== {11'd1, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0})
      $display("[TB] FAIL first_advance: got %h expected %h", dut_vec(),
               {11'd1, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0});
    else passed++;
  endtask

  // One full frame period with the enable high; every pixel is visited once
  task automatic test_line_scan();
    int hs_cnt, vs_cnt, fs_cnt, ad_cnt;
    hs_cnt = 0; vs_cnt = 0; fs_cnt = 0; ad_cnt = 0;
    ce_in = 1'b1;
    for (int i = 0; i < 160; i++) begin
      @(negedge clk_in);
      model_step(1'b1);
      checks++;
      if (dut_vec() !== model_vec())
        $display("[TB] FAIL scan_pixel: cycle %0d got %h expected %h", i, dut_vec(), model_vec());
      else passed++;
      hs_cnt += int'(hsync_out);
      vs_cnt += int'(vsync_out);
      fs_cnt += int'(frame_start_out);
      ad_cnt += int'(active_draw_out);
    end
    checks++;
    if (hs_cnt !== 30) $display("[TB] FAIL hsync_clocks: got %0d expected 30", hs_cnt);
    else passed++;
    checks++;
    if (vs_cnt !== 32) $display("[TB] FAIL vsync_clocks: got %0d expected 32", vs_cnt);
    else passed++;
    checks++;
    if (fs_cnt !== 1) $display("[TB] FAIL frame_start_clocks: got %0d expected 1", fs_cnt);
    else passed++;
    checks++;
    if (ad_cnt !== 48) $display("[TB] FAIL active_clocks: got %0d expected 48", ad_cnt);
    else passed++;
  endtask

  // 50% enable: every enabled edge is followed by a disabled one, which
  // also covers the strobe landing just before the enable drops
  task automatic test_enable_gating();
    bit ce;
    int fs_cnt;
    fs_cnt = 0;
    for (int i = 0; i < 340; i++) begin
      ce = (i % 2) == 0;
      ce_in = ce;
      @(negedge clk_in);
      model_step(ce);
      checks++;
      if (dut_vec() !== model_vec())
        $display("[TB] FAIL gated_pixel: cycle %0d ce %0d got %h expected %h",
                 i, ce, dut_vec(), model_vec());
      else passed++;
      fs_cnt += int'(frame_start_out);
    end
    checks++;
    if (fs_cnt !== 1) $display("[TB] FAIL gated_frame_starts: got %0d expected 1", fs_cnt);
    else passed++;
    ce_in = 1'b1;
  endtask

  // Five frames from a fresh reset; the index seen at each strobe is 1,2,3,0,1
  task automatic test_frame_counter();
    int seen[$];
    int want[5];
    want = '{1, 2, 3, 0, 1};
    rst_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    model_reset();
    ce_in = 1'b1;
    for (int i = 0; i < 820; i++) begin
      @(negedge clk_in);
      model_step(1'b1);
      checks++;
      if (dut_vec() !== model_vec())
        $display("[TB] FAIL frame_pixel: cycle %0d got %h expected %h", i, dut_vec(), model_vec());
      else passed++;
      if (frame_start_out === 1'b1) seen.push_back(int'(frame_count_out));
    end
    checks++;
    if (seen.size() !== 5) $display("[TB] FAIL frame_strobe_count: got %0d expected 5", seen.size());
    else passed++;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (k >= seen.size())
        $display("[TB] FAIL frame_index_%0d: got none expected %0d", k, want[k]);
      else if (seen[k] !== want[k])
        $display("[TB] FAIL frame_index_%0d: got %0d expected %0d", k, seen[k], want[k]);
      else passed++;
    end
  endtask

  // Reset asserted between clock edges at (7,3) of the second frame
  task automatic test_async_reset();
    rst_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    model_reset();
    ce_in = 1'b1;
    repeat (216) begin
      @(negedge clk_in);
      model_step(1'b1);
    end
    checks++;
    if ({hcount_out, vcount_out, frame_count_out} !== {11'd7, 10'd3, 6'd1})
      $display("[TB] FAIL pre_reset_position: got h=%0d v=%0d f=%0d expected h=7 v=3 f=1",
               hcount_out, vcount_out, frame_count_out);
    else passed++;

    #2 rst_in = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== 31'd0)
      $display("[TB] FAIL async_clear: got %h expected %h", dut_vec(), 31'd0);
    else passed++;

    @(negedge clk_in);
    rst_in = 1'b1;
    model_reset();
    @(negedge clk_in);
    model_step(1'b1);
    checks++;
    if (dut_vec() !== {11'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0})
      $display("[TB] FAIL restart_origin: got %h expected %h", dut_vec(),
               {11'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0});
    else passed++;

    @(negedge clk_in);
    model_step(1'b1);
    checks++;
    if (dut_vec() !== {11'd1, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0})
      $display("[TB] FAIL restart_advance: got %h expected %h", dut_vec(),
               {11'd1, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0});
    else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst_in = 1'b0;
    ce_in  = 1'b0;
    model_reset();
    test_reset();
    test_line_scan();
    test_enable_gating();
    test_frame_counter();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Raster timing source that drives the `hcount_in`/`vcount_in`/`start_in` inputs of `render` and the HDMI/TMDS output path.
- Free-running horizontal and vertical counters for 1280x720 timing (1650x750 total), with a pixel-clock enable.
- Produces registered hsync, vsync and active-draw flags, a one-cycle frame-start strobe at the start of vertical blanking, and a frame counter.

Parameters:
- ACTIVE_H, 1280, visible pixels per line
- H_FRONT, 110, horizontal front porch
- H_SYNC, 40, hsync width
- H_BACK, 220, horizontal back porch
- ACTIVE_V, 720, visible lines
- V_FRONT, 5, vertical front porch
- V_SYNC, 5, vsync width
- V_BACK, 20, vertical back porch
- FPS, 60, frame counter modulus

Ports:
- clk_in  input  1  system clock, all state on rising edge
- rst_in  input  1  reset, asynchronous assert, active-low (0 = reset)
- ce_in  input  1  pixel enable; counters advance only on edges where ce_in=1
- hcount_out  output  11  current pixel column, 0..H_TOTAL-1
- vcount_out  output  10  current line, 0..V_TOTAL-1
- hsync_out  output  1  horizontal sync, active-high
- vsync_out  output  1  vertical sync, active-high
- active_draw_out  output  1  1 when the pixel is inside the visible area
- frame_start_out  output  1  one-clk pulse at (ACTIVE_H, ACTIVE_V), feeds render start_in
- frame_count_out  output  6  frame index, 0..FPS-1

Behaviour:
- H_TOTAL = ACTIVE_H + H_FRONT + H_SYNC + H_BACK = 1650.
- V_TOTAL = ACTIVE_V + V_FRONT + V_SYNC + V_BACK = 750.
- Reset (rst_in=0, asynchronous): every output is 0 and the internal `primed` flag is cleared.
- States:
  - UNPRIMED: after reset. The first clk edge with ce_in=1 loads pixel (0,0) with active_draw_out=1 and sets `primed`. The counters do not advance on this edge.
  - RUN: each clk edge with ce_in=1 advances one pixel.
- Advance rules:
  - hcount wraps H_TOTAL-1 -> 0 and increments vcount.
  - vcount wraps V_TOTAL-1 -> 0 on the same edge where hcount wraps.
  - (1649, 749) -> (0, 0).
- ce_in=0: counters and all level outputs hold. frame_start_out still clears (see pulse rule).
- All outputs are registered and decoded from the next count, so every output describes the same pixel as hcount_out/vcount_out. There is no extra pipeline skew.
- Decodes (half-open ranges):
  - hsync_out = 1 iff hcount in [ACTIVE_H+H_FRONT, ACTIVE_H+H_FRONT+H_SYNC) = [1390, 1430).
  - vsync_out = 1 iff vcount in [ACTIVE_V+V_FRONT, ACTIVE_V+V_FRONT+V_SYNC) = [725, 730). It is asserted for the whole of those lines, including the horizontal blanking portion.
  - active_draw_out = 1 iff hcount < ACTIVE_H and vcount < ACTIVE_V.
- Pulse rule:
  - frame_start_out = 1 for exactly one clk, the cycle right after the edge that loads (ACTIVE_H, ACTIVE_V) = (1280, 720).
  - On the next clk edge it returns to 0 regardless of ce_in.
- frame_count_out increments on the same edge that raises frame_start_out. It wraps FPS-1 -> 0.
- Reset mid-frame: everything returns to 0 immediately (asynchronous) and `primed` clears. Restart goes through UNPRIMED, giving (0,0) with no spurious frame_start_out.
- Widths: the counters never exceed their maximums, so no overflow handling is needed. Parameter legality (sums fitting in 11/10 bits) is the integrator's responsibility.

Test Plan:
- Reset: hold rst_in=0 for 3 clks with ce_in=1 -> all outputs 0. Release -> first ce edge gives h=0, v=0, active_draw_out=1; the next edge gives h=1.
- Line scan (ce_in=1): active_draw_out=1 for h 0..1279 and drops at h=1280. hsync_out rises at h=1390 and falls at h=1430 (40 clks). h=1649 is followed by h=0 with v+1.
- Frame scan: frame_start_out is high for exactly 1 clk, when (h,v)=(1280,720).
  - vsync_out is high for exactly 5*1650=8250 clks (v 725..729).
  - (1649,749) is followed by (0,0), with 1650*750=1,237,500 clks per frame.
- Enable gating: toggle ce_in at 50% duty -> counts advance only on ce edges, and level outputs hold while ce_in=0.
  - With ce_in low right after (1280,720) is loaded, frame_start_out still lasts 1 clk only.
- Frame counter with FPS=4 override: run 5 frames -> frame_count_out sequence 1,2,3,0,1.
- Asynchronous reset mid-frame at (700,300), applied between clock edges -> outputs go to 0 without waiting for a clk edge. After release, restart at (0,0) with frame_count_out=0.
